// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, default bit timing and data width.
// The receiver uses the same encodings so that both sides decode state dumps identically.
package uart_pkg;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line signals of the UART transmitter.
// master: the byte producer; slave: the transmitter itself.
interface uart_tx_if;
    import uart_pkg::*;

    logic              i_Tx_DV;
    logic [DATA_W-1:0] i_Tx_Byte;
    logic              o_Tx_Ready;
    logic              o_Tx_Serial;
    logic              o_Tx_Active;
    logic              o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter. The pointers carry one extra wrap
// bit so full and empty can be told apart without a separate occupancy counter.
// A full FIFO refuses writes even when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Rst_L,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             wr_en;
    logic             rd_fire;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign wr_ready = !full;
    assign wr_en    = wr_valid && !full;
    assign rd_fire  = rd_en && !empty;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset discards everything buffered.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)   wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: buffers bytes in a small FIFO and shifts each out LSB first
// between a low start bit and a high stop bit. o_Tx_Done pulses for one cycle after
// the stop bit, and an idle cycle always follows before the next frame starts.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     i_Clock,
    input  logic     i_Rst_L,
    uart_tx_if.slave tx
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t       state;
    logic [CW-1:0]     clk_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              serial_r;
    logic              active_r;
    logic              done_r;

    logic              fifo_ready;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              pop;

    // The head byte is consumed only while the line is idle.
    assign pop = (state == IDLE) && !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .i_Clock  (i_Clock),
        .i_Rst_L  (i_Rst_L),
        .wr_valid (tx.i_Tx_DV),
        .wr_data  (tx.i_Tx_Byte),
        .wr_ready (fifo_ready),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .empty    (fifo_empty)
    );

    assign tx.o_Tx_Ready  = fifo_ready;
    assign tx.o_Tx_Serial = serial_r;
    assign tx.o_Tx_Active = active_r;
    assign tx.o_Tx_Done   = done_r;

    // Capture the popped byte; it only needs to be valid from START onwards.
    always_ff @(posedge i_Clock) begin
        if (pop) shift_reg <= fifo_rd_data;
    end

    // Frame sequencer; line level for the next cycle is decided on each transition.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            serial_r <= 1'b1;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    serial_r <= 1'b1;
                    active_r <= 1'b0;
                    clk_cnt  <= '0;
                    bit_idx  <= '0;
                    if (!fifo_empty) begin
                        state    <= START;
                        serial_r <= 1'b0;
                        active_r <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt  <= '0;
                        state    <= DATA;
                        serial_r <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            serial_r <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            serial_r <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt  <= '0;
                        state    <= CLEANUP;
                        active_r <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                CLEANUP: begin
                    serial_r <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    clk_cnt  <= '0;
                    bit_idx  <= '0;
                    serial_r <= 1'b1;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three transmitters (4, 2 and 255 clocks per bit) share clock
// and reset; a selector routes the one under test to a common set of observed signals.
`timescale 1ns/1ps
module tb_uart_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   sel   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if if4 ();
    uart_tx_if if2 ();
    uart_tx_if if255 ();

    uart_tx #(.CLKS_PER_BIT(4),   .FIFO_DEPTH(4)) u4   (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if4));
    uart_tx #(.CLKS_PER_BIT(2),   .FIFO_DEPTH(4)) u2   (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if2));
    uart_tx #(.CLKS_PER_BIT(255), .FIFO_DEPTH(4)) u255 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(if255));

    logic ser, act, dn, rdy;

    always_comb begin
        ser = if4.o_Tx_Serial;
        act = if4.o_Tx_Active;
        dn  = if4.o_Tx_Done;
        rdy = if4.o_Tx_Ready;
        case (sel)
            1: begin
                ser = if2.o_Tx_Serial;
                act = if2.o_Tx_Active;
                dn  = if2.o_Tx_Done;
                rdy = if2.o_Tx_Ready;
            end
            2: begin
                ser = if255.o_Tx_Serial;
                act = if255.o_Tx_Active;
                dn  = if255.o_Tx_Done;
                rdy = if255.o_Tx_Ready;
            end
            default: ;
        endcase
    end

    // Wait (at negedges) for the selected line to go low; an expired budget counts as a failure.
    task automatic wait_start(input int budget, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ser === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL %s start: no start bit within %0d cycles", tag, budget);
        end
    endtask

    // Check one whole frame cycle by cycle, decode it mid-bit like a receiver, then the done pulse.
    task automatic check_frame(input int cpb, input logic [7:0] exp, input string tag,
                               output int t_start);
        logic [9:0] frame;
        logic [9:0] dec;
        bit         ok;
        frame = {1'b1, exp, 1'b0};
        dec   = '0;
        wait_start(cpb * 12 + 64, tag, ok);
        t_start = cyc;
        if (!ok) return;
        for (int i = 0; i < 10 * cpb; i++) begin
            compared++;
            if (ser !== frame[i / cpb] || act !== 1'b1) begin
                mismatched++;
                $display("FAIL %s line cycle %0d: serial=%b active=%b, expected serial=%b active=1",
                         tag, i, ser, act, frame[i / cpb]);
            end
            if (i % cpb == cpb / 2) dec[i / cpb] = ser;
            @(negedge clk);
        end
        compared++;
        if (dec[8:1] !== exp) begin
            mismatched++;
            $display("FAIL %s decode: got 0x%02h, expected 0x%02h", tag, dec[8:1], exp);
        end
        compared++;
        if (dn !== 1'b1 || act !== 1'b0 || ser !== 1'b1) begin
            mismatched++;
            $display("FAIL %s done: done=%b active=%b serial=%b, expected 1 0 1", tag, dn, act, ser);
        end
        @(negedge clk);
        compared++;
        if (dn !== 1'b0) begin
            mismatched++;
            $display("FAIL %s done width: done=%b one cycle later, expected 0", tag, dn);
        end
    endtask

    task automatic test_reset();
        int bad;
        sel   = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({ser, act, dn, rdy} !== 4'b1001) begin
            mismatched++;
            $display("FAIL reset outputs: serial/active/done/ready=%b, expected 1001", {ser, act, dn, rdy});
        end
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({ser, act, dn, rdy} !== 4'b1001) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL reset idle: %0d active cycles after reset, expected 0", bad);
        end
    endtask

    task automatic test_single();
        int w, ts;
        sel = 0;
        @(negedge clk);
        if4.i_Tx_DV   = 1'b1;
        if4.i_Tx_Byte = 8'hA5;
        @(negedge clk);
        w             = cyc;
        if4.i_Tx_DV   = 1'b0;
        if4.i_Tx_Byte = 8'h00;
        compared++;
        if (ser !== 1'b1) begin
            mismatched++;
            $display("FAIL single early: serial=%b right after write edge, expected 1", ser);
        end
        check_frame(4, 8'hA5, "single", ts);
        compared++;
        if (ts - w != 1) begin
            mismatched++;
            $display("FAIL single latency: start %0d cycles after write, expected 1", ts - w);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        int         ts [4];
        b = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        sel = 0;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    compared++;
                    if (rdy !== 1'b1) begin
                        mismatched++;
                        $display("FAIL b2b ready %0d: ready=%b, expected 1", k, rdy);
                    end
                    if4.i_Tx_DV   = 1'b1;
                    if4.i_Tx_Byte = b[k];
                    @(negedge clk);
                end
                if4.i_Tx_DV   = 1'b0;
                if4.i_Tx_Byte = 8'hEE;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    check_frame(4, b[k], $sformatf("b2b%0d", k), ts[k]);
                    if (k > 0) begin
                        compared++;
                        if (ts[k] - ts[k-1] != 42) begin
                            mismatched++;
                            $display("FAIL b2b spacing %0d: %0d cycles, expected 42", k, ts[k] - ts[k-1]);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_fill();
        logic [7:0] b [6];
        int         ts, bad;
        logic       exp_rdy;
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sel = 0;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    exp_rdy = (k < 5);
                    compared++;
                    if (rdy !== exp_rdy) begin
                        mismatched++;
                        $display("FAIL fill ready %0d: ready=%b, expected %b", k, rdy, exp_rdy);
                    end
                    if4.i_Tx_DV   = 1'b1;
                    if4.i_Tx_Byte = b[k];
                    @(negedge clk);
                end
                if4.i_Tx_DV   = 1'b0;
                if4.i_Tx_Byte = 8'h00;
            end
            begin
                check_frame(4, b[0], "fill0", ts);
                compared++;
                if (rdy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL fill ready before pop: ready=%b, expected 0", rdy);
                end
                @(negedge clk);
                compared++;
                if (rdy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL fill ready after pop: ready=%b, expected 1", rdy);
                end
                for (int k = 1; k < 5; k++) check_frame(4, b[k], $sformatf("fill%0d", k), ts);
            end
        join
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (ser !== 1'b1 || act !== 1'b0) bad++;
            @(negedge clk);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL fill refused byte: %0d busy cycles after fifth frame, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [3];
        bit         ok;
        int         bad;
        b = '{8'h81, 8'h12, 8'h34};
        sel = 0;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    if4.i_Tx_DV   = 1'b1;
                    if4.i_Tx_Byte = b[k];
                    @(negedge clk);
                end
                if4.i_Tx_DV = 1'b0;
            end
            begin
                wait_start(100, "rstmid", ok);
                if (ok) begin
                    repeat (18) @(negedge clk);
                    compared++;
                    if (ser !== 1'b0 || act !== 1'b1) begin
                        mismatched++;
                        $display("FAIL rstmid bit3: serial=%b active=%b, expected 0 1", ser, act);
                    end
                end
            end
        join
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (ser !== 1'b1 || act !== 1'b0 || rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid abort: serial=%b active=%b ready=%b, expected 1 0 1", ser, act, rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ser !== 1'b1 || act !== 1'b0 || rdy !== 1'b1) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL rstmid discard: %0d busy cycles after reset, expected 0", bad);
        end
    endtask

    task automatic test_boundary();
        int ts;
        sel = 1;
        @(negedge clk);
        if2.i_Tx_DV   = 1'b1;
        if2.i_Tx_Byte = 8'h5A;
        @(negedge clk);
        if2.i_Tx_DV   = 1'b0;
        check_frame(2, 8'h5A, "cpb2", ts);
        sel = 2;
        @(negedge clk);
        if255.i_Tx_DV   = 1'b1;
        if255.i_Tx_Byte = 8'h5A;
        @(negedge clk);
        if255.i_Tx_DV   = 1'b0;
        check_frame(255, 8'h5A, "cpb255", ts);
        sel = 0;
    endtask

    initial begin
        if4.i_Tx_DV     = 1'b0;
        if4.i_Tx_Byte   = 8'h00;
        if2.i_Tx_DV     = 1'b0;
        if2.i_Tx_Byte   = 8'h00;
        if255.i_Tx_DV   = 1'b0;
        if255.i_Tx_Byte = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
